branch_resolve_predict: RTL and testbench

Parametrised successor to the single-cycle branch comparator, for the pipelined core. It resolves branch conditions in EX using the existing 5-bit BrOp encoding and registers the outcome, giving one cycle of latency. It also holds a PC-indexed branch history table (BHT) of 2-bit saturating counters that IF reads for a taken/not-taken prediction. At resolve time it flags mispredictions and keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_pkg.sv | 21 ++
 rtl/branch_cond_eval.sv | 23 ++
 rtl/branch_resolve_predict.sv | 83 ++++++++
 tb/tb_branch_resolve_predict.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared BrOp encoding, 2-bit BHT counter states and conditional-op helper
package branch_pkg;
  typedef enum logic [4:0] {
    BR_NEVER  = 5'b00000,
    BR_ALWAYS = 5'b10000,
    BR_EQ     = 5'b01000,
    BR_NE     = 5'b01001,
    BR_LT     = 5'b01100,
    BR_GE     = 5'b01101,
    BR_LTU    = 5'b01110,
    BR_GEU    = 5'b01111
  } brop_e;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  // Only real compare ops train the BHT; reserved 01010/01011 are excluded.
  function automatic logic is_conditional(input logic [4:0] op);
    return op inside {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU};
  endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch condition for the 5-bit BrOp encoding
// Ports: rs1, rs2 operands; BrOp operation; taken resolved condition.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      BrOp,
  output logic            taken
);
  logic eq, lt, ltu;
  // BrOp[0] inverts the base compare (eq/ne, lt/ge, ltu/geu); BrOp[1] picks unsigned.
  always_comb begin
    eq    = rs1 == rs2;
    lt    = $signed(rs1) < $signed(rs2);
    ltu   = rs1 < rs2;
    taken = BrOp[4] ? 1'b1 :
            !is_conditional(BrOp) ? 1'b0 :
            BrOp[2] ? ((BrOp[1] ? ltu : lt) ^ BrOp[0]) : (eq ^ BrOp[0]);
  end
endmodule

// File: rtl/branch_resolve_predict.sv
// branch_resolve_predict: registered branch resolve with 2-bit BHT prediction and statistics
// Ports: pred_pc -> pred_taken (combinational lookup); res_valid/res_pc/res_pred/rs1/rs2/BrOp
// resolve -> out_valid/NextPcSrc/mispredict one cycle later; stat_clr clears
// stat_branches/stat_mispredicts.
module branch_resolve_predict
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pred_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [XLEN-1:0]   res_pc,
  input  logic              res_pred,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic [4:0]        BrOp,
  output logic              out_valid,
  output logic              NextPcSrc,
  output logic              mispredict,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  logic [1:0] bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] pidx, ridx;
  logic taken, cond, miss;
  logic [1:0] ctr, ctr_d;
  logic valid_q, taken_q, miss_q;
  logic [STAT_W-1:0] br_q, br_d, mis_q, mis_d;
  logic unused_pc_bits;
  branch_cond_eval #(.XLEN(XLEN)) u_eval (
    .rs1   (rs1),
    .rs2   (rs2),
    .BrOp  (BrOp),
    .taken (taken)
  );
  assign pidx = pred_pc[IDX_W+1:2];
  assign ridx = res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0], res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};
  // Lookup reads the stored counter directly, so a same-cycle update is not visible until the next cycle.
  assign pred_taken = bht_q[pidx][1];
  always_comb begin
    cond  = res_valid && is_conditional(BrOp);
    miss  = res_valid && (taken != res_pred);
    ctr   = bht_q[ridx];
    ctr_d = taken ? ((ctr == ST) ? ST : ctr + 2'd1) : ((ctr == SNT) ? SNT : ctr - 2'd1);
    br_d  = stat_clr ? '0 : (cond && !(&br_q)) ? br_q + STAT_W'(1) : br_q;
    mis_d = stat_clr ? '0 : (miss && !(&mis_q)) ? mis_q + STAT_W'(1) : mis_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      miss_q  <= 1'b0;
      br_q    <= '0;
      mis_q   <= '0;
    end else begin
      valid_q <= res_valid;
      taken_q <= res_valid && taken;
      miss_q  <= miss;
      br_q    <= br_d;
      mis_q   <= mis_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= WNT;
    end else if (cond) begin
      bht_q[ridx] <= ctr_d;
    end
  end
  assign out_valid        = valid_q;
  assign NextPcSrc        = taken_q;
  assign mispredict       = miss_q;
  assign stat_branches    = br_q;
  assign stat_mispredicts = mis_q;
endmodule

// File: tb/tb_branch_resolve_predict.sv
// tb_branch_resolve_predict: directed scoreboard bench for branch_resolve_predict (STAT_W=4)
module tb_branch_resolve_predict;
  localparam int XLEN = 32;
  localparam int SW   = 4;
  localparam int SMAX = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [XLEN-1:0] pred_pc = '0, res_pc = '0, rs1 = '0, rs2 = '0;
  logic res_valid = 1'b0, res_pred = 1'b0, stat_clr = 1'b0;
  logic [4:0] BrOp = 5'b0;
  logic pred_taken, out_valid, NextPcSrc, mispredict;
  logic [SW-1:0] stat_branches, stat_mispredicts;
  typedef struct packed {logic v; logic t; logic m;} exp_t;
  exp_t q[$];
  int pass_n = 0, total_n = 0;
  int exp_br = 0, exp_mis = 0;
  branch_resolve_predict #(.XLEN(XLEN), .BHT_DEPTH(64), .STAT_W(SW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_pred         (res_pred),
    .rs1              (rs1),
    .rs2              (rs2),
    .BrOp             (BrOp),
    .out_valid        (out_valid),
    .NextPcSrc        (NextPcSrc),
    .mispredict       (mispredict),
    .stat_clr         (stat_clr),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );
  always #5 clk = ~clk;
  function automatic logic ref_taken(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[4]) return 1'b1;
    case (op)
      5'b01000: return a == b;
      5'b01001: return a != b;
      5'b01100: return $signed(a) < $signed(b);
      5'b01101: return $signed(a) >= $signed(b);
      5'b01110: return a < b;
      5'b01111: return a >= b;
      default:  return 1'b0;
    endcase
  endfunction
  function automatic logic ref_cond(input logic [4:0] op);
    return op == 5'b01000 || op == 5'b01001 || op[4:2] == 3'b011;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  // Drives one resolve cycle, pushes the expected outcome, then pops and checks it after the edge.
  task automatic resolve(input logic v, input logic [4:0] op, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic pr,
                         input logic clr = 1'b0, input int pre = -1);
    exp_t e, g;
    logic t;
    res_valid = v; BrOp = op; res_pc = pc; rs1 = a; rs2 = b; res_pred = pr; stat_clr = clr;
    t = v && ref_taken(op, a, b);
    e.v = v; e.t = t; e.m = v && (t != pr);
    q.push_back(e);
    if (clr) begin
      exp_br = 0; exp_mis = 0;
    end else begin
      if (v && ref_cond(op) && exp_br < SMAX) exp_br++;
      if (e.m && exp_mis < SMAX) exp_mis++;
    end
    if (pre >= 0) begin
      #1;
      chk("pred_same_cycle", {31'b0, pred_taken}, pre);
    end
    @(posedge clk); #1;
    res_valid = 1'b0; stat_clr = 1'b0;
    g = q.pop_front();
    chk("out_valid", {31'b0, out_valid}, {31'b0, g.v});
    chk("NextPcSrc", {31'b0, NextPcSrc}, {31'b0, g.t});
    chk("mispredict", {31'b0, mispredict}, {31'b0, g.m});
    chk("stat_branches", {28'b0, stat_branches}, exp_br);
    chk("stat_mispredicts", {28'b0, stat_mispredicts}, exp_mis);
  endtask
  initial begin
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_NextPcSrc", {31'b0, NextPcSrc}, 0);
    chk("rst_mispredict", {31'b0, mispredict}, 0);
    chk("rst_stat_br", {28'b0, stat_branches}, 0);
    chk("rst_stat_mis", {28'b0, stat_mispredicts}, 0);
    chk("rst_pred", {31'b0, pred_taken}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    resolve(1, 5'b01000, 32'h0, 32'h10, 32'h10, 0);
    resolve(1, 5'b01100, 32'h4, 32'hF0000003, 32'h2, 0);
    resolve(1, 5'b01110, 32'h4, 32'hF0000003, 32'h2, 0);
    resolve(1, 5'b01001, 32'h8, 32'h5, 32'h5, 1);
    resolve(1, 5'b01101, 32'h8, 32'h80000000, 32'h1, 0);
    resolve(1, 5'b01111, 32'h8, 32'hFFFFFFFF, 32'h1, 1);
    resolve(0, 5'b01000, 32'h8, 32'h1, 32'h1, 0);
    resolve(1, 5'b00000, 32'h0, 32'h0, 32'h0, 0, 1);
    pred_pc = 32'h40;
    #1 chk("pred_40_init", {31'b0, pred_taken}, 0);
    resolve(1, 5'b01000, 32'h40, 32'h1, 32'h1, 0);
    chk("pred_40_t1", {31'b0, pred_taken}, 1);
    resolve(1, 5'b01000, 32'h40, 32'h1, 32'h1, 1);
    chk("pred_40_t2", {31'b0, pred_taken}, 1);
    resolve(1, 5'b01000, 32'h40, 32'h1, 32'h1, 1);
    chk("pred_40_t3", {31'b0, pred_taken}, 1);
    resolve(1, 5'b01000, 32'h40, 32'h1, 32'h2, 1);
    chk("pred_40_n1", {31'b0, pred_taken}, 1);
    resolve(1, 5'b01000, 32'h40, 32'h1, 32'h2, 1);
    chk("pred_40_n2", {31'b0, pred_taken}, 0);
    resolve(1, 5'b01000, 32'h40, 32'h1, 32'h2, 0);
    resolve(1, 5'b01000, 32'h40, 32'h1, 32'h2, 0);
    chk("pred_40_n4", {31'b0, pred_taken}, 0);
    resolve(1, 5'b01000, 32'h40, 32'h3, 32'h3, 0);
    chk("pred_40_sat_low", {31'b0, pred_taken}, 0);
    pred_pc = 32'h80;
    resolve(1, 5'b01000, 32'h80, 32'h7, 32'h7, 0, 1'b0, 0);
    chk("pred_80_next", {31'b0, pred_taken}, 1);
    resolve(1, 5'b10000, 32'h80, 32'h0, 32'h1, 0);
    chk("pred_80_uncond", {31'b0, pred_taken}, 1);
    resolve(1, 5'b01010, 32'h80, 32'h1, 32'h1, 0);
    resolve(1, 5'b01011, 32'h80, 32'h1, 32'h2, 1);
    resolve(1, 5'b00101, 32'h80, 32'h1, 32'h1, 1);
    chk("pred_80_reserved", {31'b0, pred_taken}, 1);
    resolve(1, 5'b10000, 32'h0, 32'h0, 32'h0, 0, 1'b1);
    for (int i = 0; i < 16; i++) resolve(1, 5'b01000, 32'h100, 32'h9, 32'h9, 0);
    chk("stat_mis_sat", {28'b0, stat_mispredicts}, SMAX);
    chk("stat_br_sat", {28'b0, stat_branches}, SMAX);
    res_valid = 1'b1; BrOp = 5'b10000; res_pred = 1'b0;
    @(posedge clk); #1;
    res_valid = 1'b0;
    chk("pre_reset_valid", {31'b0, out_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 0);
    chk("async_rst_mis", {31'b0, mispredict}, 0);
    chk("async_rst_stat", {28'b0, stat_mispredicts}, 0);
    chk("async_rst_bht", {31'b0, pred_taken}, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
